// File: rtl/multicycle_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_alu_if: request/result bundle for the multi-cycle ALU      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [3:0]            ALUOperation;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [4:0]            shamt;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  Zero;
  logic                  Invalid;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  busy, done, ALUResult, Zero, Invalid
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output busy, done, ALUResult, Zero, Invalid
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_alu: one-cycle logic/arith ops, bit-serial SLL/SRL         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  multicycle_alu_if.slave  bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam int         HALF  = DATA_WIDTH / 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [4:0]            count;
  logic                  shift_left;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  invalid;
  logic                  done;

  logic [DATA_WIDTH-1:0] comb_result;
  logic                  comb_invalid;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  is_shift;
  logic                  go_serial;

  assign is_shift  = (bus.ALUOperation == OP_SLL) || (bus.ALUOperation == OP_SRL);
  assign go_serial = is_shift && (bus.shamt != 5'd0);

  // Shift codes only reach this path with shamt == 0, where the result is B.
  always_comb begin
    comb_result  = '0;
    comb_invalid = 1'b0;
    case (bus.ALUOperation)
      OP_AND:  comb_result = bus.A & bus.B;
      OP_OR:   comb_result = bus.A | bus.B;
      OP_NOR:  comb_result = ~(bus.A | bus.B);
      OP_ADD:  comb_result = bus.A + bus.B;
      OP_SUB:  comb_result = bus.A - bus.B;
      OP_LUI:  comb_result = {bus.B[HALF-1:0], {HALF{1'b0}}};
      OP_SLL:  comb_result = bus.B << bus.shamt;
      OP_SRL:  comb_result = bus.B >> bus.shamt;
      default: comb_invalid = 1'b1;
    endcase
  end

  assign shift_next = shift_left ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, shift_reg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      count      <= 5'd0;
      shift_left <= 1'b0;
      result     <= '0;
      zero       <= 1'b1;
      invalid    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (go_serial) begin
              shift_reg  <= bus.B;
              count      <= bus.shamt;
              shift_left <= (bus.ALUOperation == OP_SLL);
              state      <= SHIFT;
            end else begin
              result  <= comb_result;
              zero    <= (comb_result == '0);
              invalid <= comb_invalid;
              done    <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          count     <= count - 5'd1;
          // The edge that takes the counter from 1 to 0 retires the shift.
          if (count == 5'd1) begin
            result  <= shift_next;
            zero    <= (shift_next == '0);
            invalid <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = done;
  assign bus.ALUResult = result;
  assign bus.Zero      = zero;
  assign bus.Invalid   = invalid;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multicycle_alu: directed vector table plus multi-cycle sequences   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_multicycle_alu;
  logic clk;
  logic reset;

  multicycle_alu_if #(.DATA_WIDTH(32)) bus ();

  multicycle_alu #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_invalid;
  } vec_t;

  vec_t vecs [14];
  int   checks;
  int   errors;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
    bus.ALUOperation = op;
    bus.A            = a;
    bus.B            = b;
    bus.shamt        = sh;
  endtask

  // Waits up to 40 edges for done; returns edges elapsed (40 on timeout).
  task automatic wait_done(output int cyc, output int busy_cnt, output int overlap);
    cyc = 0; busy_cnt = 0; overlap = 0;
    while (cyc < 40) begin
      step();
      bus.start = 1'b0;
      cyc++;
      if (bus.busy && bus.done) overlap++;
      if (bus.busy) busy_cnt++;
      if (bus.done) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, busy_cnt, overlap, exp_lat;
    exp_lat = ((v.op == 4'b0110 || v.op == 4'b0111) && v.shamt != 5'd0) ? int'(v.shamt) + 1 : 1;
    set_inputs(v.op, v.a, v.b, v.shamt);
    bus.start = 1'b1;
    wait_done(cyc, busy_cnt, overlap);
    check({v.name, " latency"}, cyc, exp_lat);
    check({v.name, " busy cycles"}, busy_cnt, exp_lat - 1);
    check({v.name, " busy&done"}, overlap, 0);
    check({v.name, " result"}, bus.ALUResult, v.exp_result);
    check({v.name, " zero"}, {31'd0, bus.Zero}, {31'd0, v.exp_zero});
    check({v.name, " invalid"}, {31'd0, bus.Invalid}, {31'd0, v.exp_invalid});
    step();
    check({v.name, " done one cycle"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int cyc, busy_cnt, overlap, done_cnt;
    checks = 0;
    errors = 0;

    vecs[0]  = '{"and",      4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{"or",       4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 5'd0,  32'h0000_0FFF, 1'b0, 1'b0};
    vecs[2]  = '{"nor",      4'b0010, 32'h0000_00F0, 32'h0000_0F0F, 5'd0,  32'hFFFF_F000, 1'b0, 1'b0};
    vecs[3]  = '{"add",      4'b0011, 32'h0000_00F0, 32'h0000_0F0F, 5'd0,  32'h0000_0FFF, 1'b0, 1'b0};
    vecs[4]  = '{"sub",      4'b0100, 32'h0000_00F0, 32'h0000_0F0F, 5'd0,  32'hFFFF_F1E1, 1'b0, 1'b0};
    vecs[5]  = '{"lui",      4'b0101, 32'h0000_00F0, 32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0, 1'b0};
    vecs[6]  = '{"add wrap", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
    vecs[7]  = '{"sll sh0",  4'b0110, 32'h0000_0000, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
    vecs[8]  = '{"srl sh0",  4'b0111, 32'h0000_0000, 32'h8765_4321, 5'd0,  32'h8765_4321, 1'b0, 1'b0};
    vecs[9]  = '{"code1001", 4'b1001, 32'h0000_00F0, 32'h0000_0F0F, 5'd3,  32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{"sll 31",   4'b0110, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{"srl 4",    4'b0111, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
    vecs[12] = '{"sll 8",    4'b0110, 32'h0000_0000, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 1'b0, 1'b0};
    vecs[13] = '{"srl out",  4'b0111, 32'h0000_0000, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b0};

    reset     = 1'b1;
    bus.start = 1'b0;
    set_inputs(4'b0000, 32'd0, 32'd0, 5'd0);
    step();
    step();
    reset = 1'b0;
    check("reset busy",    {31'd0, bus.busy},    32'd0);
    check("reset done",    {31'd0, bus.done},    32'd0);
    check("reset result",  bus.ALUResult,        32'd0);
    check("reset zero",    {31'd0, bus.Zero},    32'd1);
    check("reset invalid", {31'd0, bus.Invalid}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // start pulsed while shifting is dropped: exactly one done, shift result kept.
    set_inputs(4'b0110, 32'd0, 32'h0000_0003, 5'd6);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    set_inputs(4'b0011, 32'd5, 32'd5, 5'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) done_cnt++;
      step();
    end
    check("ignored start done count", done_cnt, 1);
    check("ignored start result", bus.ALUResult, 32'h0000_00C0);

    // Inputs changing mid-shift must not disturb the latched operands.
    set_inputs(4'b0111, 32'd0, 32'hF000_0000, 5'd4);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    set_inputs(4'b0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd1);
    wait_done(cyc, busy_cnt, overlap);
    check("mid-shift change latency", cyc, 4);
    check("mid-shift change result", bus.ALUResult, 32'h0F00_0000);

    // Start accepted in the done cycle completes one cycle later.
    set_inputs(4'b0110, 32'd0, 32'h0000_0001, 5'd2);
    bus.start = 1'b1;
    wait_done(cyc, busy_cnt, overlap);
    check("pre-chain result", bus.ALUResult, 32'h0000_0004);
    check("pre-chain done", {31'd0, bus.done}, 32'd1);
    set_inputs(4'b0001, 32'h0000_00A0, 32'h0000_000B, 5'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("done-cycle start done", {31'd0, bus.done}, 32'd1);
    check("done-cycle start result", bus.ALUResult, 32'h0000_00AB);

    // Held start gives one result per cycle.
    set_inputs(4'b0011, 32'd1, 32'd2, 5'd0);
    bus.start = 1'b1;
    step();
    check("b2b first done", {31'd0, bus.done}, 32'd1);
    check("b2b first result", bus.ALUResult, 32'd3);
    set_inputs(4'b0100, 32'd5, 32'd7, 5'd0);
    step();
    bus.start = 1'b0;
    check("b2b second done", {31'd0, bus.done}, 32'd1);
    check("b2b second result", bus.ALUResult, 32'hFFFF_FFFE);
    step();
    check("b2b done drops", {31'd0, bus.done}, 32'd0);

    // Reset during an 8-bit shift: shift lost, outputs back to reset values.
    set_inputs(4'b0110, 32'd0, 32'h0000_0001, 5'd8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("shift reset busy",    {31'd0, bus.busy},    32'd0);
    check("shift reset done",    {31'd0, bus.done},    32'd0);
    check("shift reset result",  bus.ALUResult,        32'd0);
    check("shift reset zero",    {31'd0, bus.Zero},    32'd1);
    check("shift reset invalid", {31'd0, bus.Invalid}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.busy) done_cnt++;
    end
    check("no activity after shift reset", done_cnt, 0);

    // Reset and start together: reset wins, nothing accepted.
    set_inputs(4'b0001, 32'h0000_0055, 32'd0, 5'd0);
    bus.start = 1'b1;
    reset     = 1'b1;
    step();
    bus.start = 1'b0;
    reset     = 1'b0;
    step();
    check("reset+start done",   {31'd0, bus.done}, 32'd0);
    check("reset+start result", bus.ALUResult,     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
